fetch_seq: RTL and testbench

Instruction fetch/sequencing stage that sits directly upstream of the branch unit.
- Reads opcode and operand bytes from memory at the PC address.
- Classifies each opcode as a relative branch, JMP absolute, or other.
- Drives the branch unit's control inputs (branch_con, branch_uncon, branch_op, pc_inc_decoder, lower_byte_decoder) and the PC's bra_add byte.
- Hands all other opcodes to the execute stage over a valid/ack handshake.

---
 rtl/fetch_seq.sv | 172 +++++++++++++++++
 tb/tb_fetch_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// ============================================================================
// Module   : fetch_seq
// Brief    : Instruction fetch/sequencing stage feeding the branch unit and
//            handing non-branch opcodes to execute over a valid/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_seq #(
  parameter logic [7:0]  JMP_OPCODE = 8'h4C,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address_i,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_ready_i,
  input  logic        op_ack_i,
  output logic [15:0] mem_addr_o,
  output logic        mem_rd_o,
  output logic [7:0]  opcode_o,
  output logic [7:0]  bra_add_o,
  output logic        op_valid_o,
  output logic        branch_con_o,
  output logic        branch_uncon_o,
  output logic [2:0]  branch_op_o,
  output logic        pc_inc_decoder_o,
  output logic        lower_byte_decoder_o,
  output logic        fault_o
);

  localparam logic [7:0] C_LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    FETCH_REL = 3'd1,
    FETCH_LO  = 3'd2,
    FETCH_HI  = 3'd3,
    STEP      = 3'd4,
    ISSUE     = 3'd5,
    HALT      = 3'd6
  } state_t;

  // Which byte was just accepted; selects the extra STEP pulse and STEP's exit.
  typedef enum logic [1:0] {
    K_OP  = 2'd0,
    K_REL = 2'd1,
    K_LO  = 2'd2,
    K_HI  = 2'd3
  } kind_t;

  state_t     state_q, state_d;
  kind_t      kind_q, kind_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] bra_add_q, bra_add_d;
  logic [2:0] branch_op_q, branch_op_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_OP;
      kind_q      <= K_OP;
      cnt_q       <= 8'd0;
      opcode_q    <= 8'd0;
      bra_add_q   <= 8'd0;
      branch_op_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      cnt_q       <= cnt_d;
      opcode_q    <= opcode_d;
      bra_add_q   <= bra_add_d;
      branch_op_q <= branch_op_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    kind_d               = kind_q;
    cnt_d                = cnt_q;
    opcode_d             = opcode_q;
    bra_add_d            = bra_add_q;
    branch_op_d          = branch_op_q;
    mem_rd_o             = 1'b0;
    op_valid_o           = 1'b0;
    branch_con_o         = 1'b0;
    branch_uncon_o       = 1'b0;
    pc_inc_decoder_o     = 1'b0;
    lower_byte_decoder_o = 1'b0;
    fault_o              = 1'b0;

    case (state_q)
      FETCH_OP, FETCH_REL, FETCH_LO, FETCH_HI: begin
        mem_rd_o = 1'b1;
        if (mem_ready_i) begin
          cnt_d   = 8'd0;
          state_d = STEP;
          case (state_q)
            FETCH_OP: begin
              opcode_d = mem_data_i;
              kind_d   = K_OP;
            end
            FETCH_REL: begin
              bra_add_d   = mem_data_i;
              branch_op_d = opcode_q[7:5];
              kind_d      = K_REL;
            end
            FETCH_LO: begin
              bra_add_d = mem_data_i;
              kind_d    = K_LO;
            end
            default: begin
              bra_add_d = mem_data_i;
              kind_d    = K_HI;
            end
          endcase
        end else if (cnt_q >= C_LIMIT_M1) begin
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      STEP: begin
        cnt_d                = 8'd0;
        pc_inc_decoder_o     = (kind_q != K_HI);
        branch_con_o         = (kind_q == K_REL);
        lower_byte_decoder_o = (kind_q == K_LO);
        branch_uncon_o       = (kind_q == K_HI);
        case (kind_q)
          K_OP: begin
            // Relative-branch pattern takes priority over the JMP opcode match.
            if (opcode_q[4:0] == 5'b10000) begin
              state_d = FETCH_REL;
            end else if (opcode_q == JMP_OPCODE) begin
              state_d = FETCH_LO;
            end else begin
              state_d = ISSUE;
            end
          end
          K_LO:    state_d = FETCH_HI;
          default: state_d = FETCH_OP;
        endcase
      end

      ISSUE: begin
        cnt_d      = 8'd0;
        op_valid_o = 1'b1;
        if (op_ack_i) begin
          state_d = FETCH_OP;
        end
      end

      HALT: begin
        fault_o = 1'b1;
      end

      default: begin
        state_d = FETCH_OP;
      end
    endcase
  end

  assign mem_addr_o  = address_i;
  assign opcode_o    = opcode_q;
  assign bra_add_o   = bra_add_q;
  assign branch_op_o = branch_op_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_seq.sv
// ============================================================================
// Module   : tb_fetch_seq
// Brief    : Self-checking bench for fetch_seq using an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_seq;

  localparam int unsigned WL = 15;

  // Control bit positions: {mem_rd, pc_inc, con, uncon, lower, op_valid, fault}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] RD   = 7'b1000000;
  localparam logic [6:0] INC  = 7'b0100000;
  localparam logic [6:0] CON  = 7'b0010000;
  localparam logic [6:0] UNC  = 7'b0001000;
  localparam logic [6:0] LOW  = 7'b0000100;
  localparam logic [6:0] OV   = 7'b0000010;
  localparam logic [6:0] FLT  = 7'b0000001;

  typedef struct packed {
    logic [6:0] ctl;
    logic [7:0] opc;
    logic [7:0] bra;
    logic [2:0] bop;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       rdy;
    logic [7:0] data;
    logic       ack;
    obs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address_i = 16'h0000;
  logic [7:0]  mem_data_i = 8'h00;
  logic        mem_ready_i = 1'b0;
  logic        op_ack_i = 1'b0;
  logic [15:0] mem_addr_o;
  logic        mem_rd_o;
  logic [7:0]  opcode_o;
  logic [7:0]  bra_add_o;
  logic        op_valid_o;
  logic        branch_con_o;
  logic        branch_uncon_o;
  logic [2:0]  branch_op_o;
  logic        pc_inc_decoder_o;
  logic        lower_byte_decoder_o;
  logic        fault_o;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t sb[$];

  fetch_seq #(.JMP_OPCODE(8'h4C), .WAIT_LIMIT(WL)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .address_i            (address_i),
    .mem_data_i           (mem_data_i),
    .mem_ready_i          (mem_ready_i),
    .op_ack_i             (op_ack_i),
    .mem_addr_o           (mem_addr_o),
    .mem_rd_o             (mem_rd_o),
    .opcode_o             (opcode_o),
    .bra_add_o            (bra_add_o),
    .op_valid_o           (op_valid_o),
    .branch_con_o         (branch_con_o),
    .branch_uncon_o       (branch_uncon_o),
    .branch_op_o          (branch_op_o),
    .pc_inc_decoder_o     (pc_inc_decoder_o),
    .lower_byte_decoder_o (lower_byte_decoder_o),
    .fault_o              (fault_o)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(input logic r, input logic rdy, input logic [7:0] d,
                             input logic ack, input logic [6:0] ctl,
                             input logic [7:0] opc, input logic [7:0] bra,
                             input logic [2:0] bop);
    vec_t v;
    v.rst  = r;
    v.rdy  = rdy;
    v.data = d;
    v.ack  = ack;
    v.exp  = '{ctl: ctl, opc: opc, bra: bra, bop: bop};
    return v;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ctl = {mem_rd_o, pc_inc_decoder_o, branch_con_o, branch_uncon_o,
             lower_byte_decoder_o, op_valid_o, fault_o};
    o.opc = opcode_o;
    o.bra = bra_add_o;
    o.bop = branch_op_o;
    return o;
  endfunction

  // Drive one cycle's inputs just after the edge, queue its expectation, then
  // wait for the opposite edge where the caller samples.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst         = v.rst;
    mem_ready_i = v.rdy;
    mem_data_i  = v.data;
    op_ack_i    = v.ack;
    sb.push_back(v.exp);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst         = 1'b1;
    mem_ready_i = 1'b0;
    op_ack_i    = 1'b0;
    mem_data_i  = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_reset();
    vec_t v;
    obs_t e, g;
    do_reset();
    address_i = 16'hBEEF;
    v = V(0, 0, 8'h00, 0, RD, 8'h00, 8'h00, 3'd0);
    apply(v);
    e = sb.pop_front();
    g = sample();
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL reset_state got=%h want=%h", g, e);
    end
    n_vec++;
    if (mem_addr_o !== 16'hBEEF) begin
      n_err++;
      $display("FAIL mem_addr_a got=%h want=%h", mem_addr_o, 16'hBEEF);
    end
    address_i = 16'h5A3C;
    #1;
    n_vec++;
    if (mem_addr_o !== 16'h5A3C) begin
      n_err++;
      $display("FAIL mem_addr_b got=%h want=%h", mem_addr_o, 16'h5A3C);
    end
  endtask

  task automatic test_issue();
    vec_t l[$];
    obs_t e, g;
    do_reset();
    l.push_back(V(0, 1, 8'hEA, 0, RD,  8'h00, 8'h00, 3'd0));
    l.push_back(V(0, 1, 8'hEA, 0, INC, 8'hEA, 8'h00, 3'd0));
    // Long ISSUE wait, beyond the fetch timeout, with stray mem_ready.
    for (int i = 0; i < 20; i++) l.push_back(V(0, 1, 8'hD0, 0, OV, 8'hEA, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 1, OV, 8'hEA, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, RD, 8'hEA, 8'h00, 3'd0));
    foreach (l[i]) begin
      apply(l[i]);
      e = sb.pop_front();
      g = sample();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL issue[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  task automatic test_branch_rel();
    vec_t l[$];
    obs_t e, g;
    do_reset();
    l.push_back(V(0, 1, 8'hD0, 0, RD,        8'h00, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, INC,       8'hD0, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h55, 0, RD,        8'hD0, 8'h00, 3'd0));
    l.push_back(V(0, 1, 8'h55, 0, RD,        8'hD0, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, INC | CON, 8'hD0, 8'h55, 3'b110));
    l.push_back(V(0, 0, 8'h00, 0, RD,        8'hD0, 8'h55, 3'b110));
    foreach (l[i]) begin
      apply(l[i]);
      e = sb.pop_front();
      g = sample();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL branch_rel[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  // Continues from test_branch_rel without reset so branch_op visibly changes.
  task automatic test_ack_ignored();
    vec_t l[$];
    obs_t e, g;
    l.push_back(V(0, 1, 8'h10, 1, RD,        8'hD0, 8'h55, 3'b110));
    l.push_back(V(0, 0, 8'h00, 1, INC,       8'h10, 8'h55, 3'b110));
    l.push_back(V(0, 1, 8'hAB, 1, RD,        8'h10, 8'h55, 3'b110));
    l.push_back(V(0, 0, 8'h00, 1, INC | CON, 8'h10, 8'hAB, 3'b000));
    l.push_back(V(0, 0, 8'h00, 1, RD,        8'h10, 8'hAB, 3'b000));
    foreach (l[i]) begin
      apply(l[i]);
      e = sb.pop_front();
      g = sample();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL ack_ignored[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  // Back-to-back JMP right after the previous branch; mem_ready held in STEP.
  task automatic test_back_to_back_jmp();
    vec_t l[$];
    obs_t e, g;
    l.push_back(V(0, 1, 8'h4C, 0, RD,        8'h10, 8'hAB, 3'd0));
    l.push_back(V(0, 1, 8'h99, 0, INC,       8'h4C, 8'hAB, 3'd0));
    l.push_back(V(0, 1, 8'h34, 0, RD,        8'h4C, 8'hAB, 3'd0));
    l.push_back(V(0, 1, 8'h77, 0, INC | LOW, 8'h4C, 8'h34, 3'd0));
    l.push_back(V(0, 1, 8'h12, 0, RD,        8'h4C, 8'h34, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, UNC,       8'h4C, 8'h12, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, RD,        8'h4C, 8'h12, 3'd0));
    foreach (l[i]) begin
      apply(l[i]);
      e = sb.pop_front();
      g = sample();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL jmp[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_jmp();
    vec_t l[$];
    obs_t e, g;
    do_reset();
    l.push_back(V(0, 1, 8'h4C, 0, RD,  8'h00, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, INC, 8'h4C, 8'h00, 3'd0));
    l.push_back(V(1, 1, 8'h34, 0, RD,  8'h4C, 8'h00, 3'd0));
    for (int i = 0; i < 5; i++) l.push_back(V(0, 0, 8'h00, 0, RD, 8'h00, 8'h00, 3'd0));
    foreach (l[i]) begin
      apply(l[i]);
      e = sb.pop_front();
      g = sample();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL reset_mid_jmp[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t l[$];
    obs_t e, g;
    do_reset();
    // WL-1 idle cycles then a byte: just inside the limit.
    for (int i = 0; i < int'(WL) - 1; i++) l.push_back(V(0, 0, 8'h00, 0, RD, 8'h00, 8'h00, 3'd0));
    l.push_back(V(0, 1, 8'hEA, 0, RD,  8'h00, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, INC, 8'hEA, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 1, OV,  8'hEA, 8'h00, 3'd0));
    for (int i = 0; i < int'(WL); i++) l.push_back(V(0, 0, 8'h00, 0, RD, 8'hEA, 8'h00, 3'd0));
    for (int i = 0; i < 4; i++) l.push_back(V(0, 1, 8'hD0, 1, FLT, 8'hEA, 8'h00, 3'd0));
    l.push_back(V(1, 1, 8'hD0, 0, FLT, 8'hEA, 8'h00, 3'd0));
    l.push_back(V(0, 0, 8'h00, 0, RD,  8'h00, 8'h00, 3'd0));
    foreach (l[i]) begin
      apply(l[i]);
      e = sb.pop_front();
      g = sample();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL timeout[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_issue();
    test_branch_rel();
    test_ack_ignored();
    test_back_to_back_jmp();
    test_reset_mid_jmp();
    test_timeout();
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
